mathb_simd_mac: RTL and testbench

Parametrised, pipelined SIMD multiply-accumulate engine for the eFPGA math unit. It is the successor to the fixed 32-bit MAC array and output mux. Operand and coefficient words are split into 1, 2, 4 or 8 lanes, selected per beat. Each lane has its own guarded accumulator with clear, rounding, scaling and saturation, and is stepped through a three-stage valid/ready pipeline. The block sits between the operand/coefficient muxes (eFPGA or TPRAM source) and the eFPGA fabric result port.

---
 rtl/mathb_simd_mac.sv | 221 ++++++++++++++++++++++
 tb/tb_mathb_simd_mac.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mathb_simd_mac.sv
// SIMD multiply-accumulate engine for the eFPGA math unit: 1/2/4/8 lanes per beat,
// per-lane guarded accumulators, three-stage valid/ready pipeline.
module mathb_simd_mac #(
  parameter int DATA_W  = 32,
  parameter int GUARD_W = 8,
  parameter int SHIFT_W = $clog2(2*DATA_W)+1
) (
  input  logic               EFPGA2MATHB_CLK,
  input  logic               acc_ff_rstn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  oper_data,
  input  logic [DATA_W-1:0]  coef_data,
  input  logic [1:0]         mode,
  input  logic               tc,
  input  logic               acc_clear,
  input  logic               acc_rnd,
  input  logic               acc_sat,
  input  logic [SHIFT_W-1:0] out_shift,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [7:0]         out_ovf
);

  logic               adv_s;
  logic               acc_we_s;
  logic               clear_eff_s;

  logic               s1_valid_r;
  logic [DATA_W-1:0]  s1_oper_r;
  logic [DATA_W-1:0]  s1_coef_r;
  logic [1:0]         s1_mode_r;
  logic               s1_tc_r;
  logic               s1_clear_r;
  logic               s1_rnd_r;
  logic               s1_sat_r;
  logic [SHIFT_W-1:0] s1_shift_r;

  logic               s2_valid_r;
  logic [1:0]         s2_mode_r;
  logic               s2_tc_r;
  logic               s2_rnd_r;
  logic               s2_sat_r;
  logic [SHIFT_W-1:0] s2_shift_r;
  logic [7:0]         s2_ovf_r;

  logic [1:0]         last_mode_r;

  logic [3:0][7:0]        s1_ovf_mode_s;
  logic [3:0][7:0]        s3_ovf_mode_s;
  logic [3:0][DATA_W-1:0] s3_data_mode_s;

  assign adv_s       = ~(out_valid & ~out_ready);
  assign in_ready    = adv_s;
  assign acc_we_s    = s1_valid_r & adv_s;
  // A mode change restarts accumulation exactly like an explicit clear.
  assign clear_eff_s = s1_clear_r | (s1_mode_r != last_mode_r);

  // Pipeline control and payload registers for S1, S2 and the output stage.
  always_ff @(posedge EFPGA2MATHB_CLK or negedge acc_ff_rstn) begin
    if (!acc_ff_rstn) begin
      s1_valid_r  <= 1'b0;
      s1_oper_r   <= {DATA_W{1'b0}};
      s1_coef_r   <= {DATA_W{1'b0}};
      s1_mode_r   <= 2'b00;
      s1_tc_r     <= 1'b0;
      s1_clear_r  <= 1'b0;
      s1_rnd_r    <= 1'b0;
      s1_sat_r    <= 1'b0;
      s1_shift_r  <= {SHIFT_W{1'b0}};
      s2_valid_r  <= 1'b0;
      s2_mode_r   <= 2'b00;
      s2_tc_r     <= 1'b0;
      s2_rnd_r    <= 1'b0;
      s2_sat_r    <= 1'b0;
      s2_shift_r  <= {SHIFT_W{1'b0}};
      s2_ovf_r    <= 8'h00;
      last_mode_r <= 2'b00;
      out_valid   <= 1'b0;
      out_data    <= {DATA_W{1'b0}};
      out_ovf     <= 8'h00;
    end else if (adv_s) begin
      s1_valid_r  <= in_valid;
      s1_oper_r   <= oper_data;
      s1_coef_r   <= coef_data;
      s1_mode_r   <= mode;
      s1_tc_r     <= tc;
      s1_clear_r  <= acc_clear;
      s1_rnd_r    <= acc_rnd;
      s1_sat_r    <= acc_sat;
      s1_shift_r  <= out_shift;
      s2_valid_r  <= s1_valid_r;
      s2_mode_r   <= s1_mode_r;
      s2_tc_r     <= s1_tc_r;
      s2_rnd_r    <= s1_rnd_r;
      s2_sat_r    <= s1_sat_r;
      s2_shift_r  <= s1_shift_r;
      s2_ovf_r    <= s1_valid_r ? s1_ovf_mode_s[s1_mode_r] : 8'h00;
      last_mode_r <= s1_valid_r ? s1_mode_r : last_mode_r;
      out_valid   <= s2_valid_r;
      if (s2_valid_r) begin
        out_data <= s3_data_mode_s[s2_mode_r];
        out_ovf  <= s3_ovf_mode_s[s2_mode_r] | s2_ovf_r;
      end
    end
  end

  for (genvar m = 0; m < 4; m++) begin : g_mode
    localparam int NL = 1 << m;
    localparam int LW = DATA_W / NL;
    localparam int PW = 2 * LW;
    localparam int AW = PW + GUARD_W;
    localparam int EW = AW + 1;

    for (genvar l = 0; l < NL; l++) begin : g_lane
      logic [LW-1:0]      a_s;
      logic [LW-1:0]      b_s;
      logic [PW-1:0]      prod_s;
      logic [EW-1:0]      prod_x_s;
      logic [EW-1:0]      acc_x_s;
      logic [EW-1:0]      sum_s;
      logic               ovf2_s;
      logic [AW-1:0]      acc_nxt_s;
      logic [AW-1:0]      acc_r;
      logic [SHIFT_W-1:0] sh_s;
      logic [EW-1:0]      inc_s;
      logic [EW-1:0]      rnd_x_s;
      logic [EW-1:0]      v_s;
      logic               fit_s;
      logic [LW-1:0]      res_s;

      // S1/S2: lane product and the next accumulator value with wrap or clamp.
      always_comb begin
        a_s = s1_oper_r[l*LW +: LW];
        b_s = s1_coef_r[l*LW +: LW];
        if (s1_tc_r) begin
          prod_s   = {{LW{a_s[LW-1]}}, a_s} * {{LW{b_s[LW-1]}}, b_s};
          prod_x_s = {{(GUARD_W+1){prod_s[PW-1]}}, prod_s};
          acc_x_s  = {acc_r[AW-1], acc_r};
        end else begin
          prod_s   = {{LW{1'b0}}, a_s} * {{LW{1'b0}}, b_s};
          prod_x_s = {{(GUARD_W+1){1'b0}}, prod_s};
          acc_x_s  = {1'b0, acc_r};
        end
        if (clear_eff_s) begin
          sum_s = prod_x_s;
        end else begin
          sum_s = acc_x_s + prod_x_s;
        end
        if (s1_tc_r) begin
          ovf2_s = sum_s[AW] ^ sum_s[AW-1];
        end else begin
          ovf2_s = sum_s[AW];
        end
        if (ovf2_s && s1_sat_r) begin
          if (!s1_tc_r) begin
            acc_nxt_s = {AW{1'b1}};
          end else if (sum_s[AW]) begin
            acc_nxt_s = {1'b1, {(AW-1){1'b0}}};
          end else begin
            acc_nxt_s = {1'b0, {(AW-1){1'b1}}};
          end
        end else begin
          acc_nxt_s = sum_s[AW-1:0];
        end
      end

      // Lane accumulator; only the bank matching the beat's mode is written.
      always_ff @(posedge EFPGA2MATHB_CLK or negedge acc_ff_rstn) begin
        if (!acc_ff_rstn) begin
          acc_r <= {AW{1'b0}};
        end else if (acc_we_s && (s1_mode_r == 2'(m))) begin
          acc_r <= acc_nxt_s;
        end
      end

      // S3: round, shift and fit the accumulator into the lane width.
      always_comb begin
        if (s2_shift_r > SHIFT_W'(PW)) begin
          sh_s = SHIFT_W'(PW);
        end else begin
          sh_s = s2_shift_r;
        end
        if (s2_rnd_r && (sh_s != {SHIFT_W{1'b0}})) begin
          inc_s = EW'(1'b1) << (sh_s - SHIFT_W'(1'b1));
        end else begin
          inc_s = {EW{1'b0}};
        end
        if (s2_tc_r) begin
          rnd_x_s = {acc_r[AW-1], acc_r} + inc_s;
          v_s     = $signed(rnd_x_s) >>> sh_s;
          fit_s   = (&v_s[AW:LW-1]) | ~(|v_s[AW:LW-1]);
        end else begin
          rnd_x_s = {1'b0, acc_r} + inc_s;
          v_s     = rnd_x_s >> sh_s;
          fit_s   = ~(|v_s[AW:LW]);
        end
        if (fit_s || !s2_sat_r) begin
          res_s = v_s[LW-1:0];
        end else if (!s2_tc_r) begin
          res_s = {LW{1'b1}};
        end else if (v_s[AW]) begin
          res_s = {1'b1, {(LW-1){1'b0}}};
        end else begin
          res_s = {1'b0, {(LW-1){1'b1}}};
        end
      end

      assign s1_ovf_mode_s[m][l]           = ovf2_s;
      assign s3_ovf_mode_s[m][l]           = ~fit_s;
      assign s3_data_mode_s[m][l*LW +: LW] = res_s;
    end

    for (genvar l = NL; l < 8; l++) begin : g_pad
      assign s1_ovf_mode_s[m][l] = 1'b0;
      assign s3_ovf_mode_s[m][l] = 1'b0;
    end
  end

endmodule

// File: tb/tb_mathb_simd_mac.sv
// Directed self-checking bench for mathb_simd_mac at DATA_W = 32.
module tb_mathb_simd_mac;
  localparam int DATA_W  = 32;
  localparam int SHIFT_W = $clog2(2*DATA_W)+1;

  logic               EFPGA2MATHB_CLK = 1'b0;
  logic               acc_ff_rstn;
  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  oper_data;
  logic [DATA_W-1:0]  coef_data;
  logic [1:0]         mode;
  logic               tc;
  logic               acc_clear;
  logic               acc_rnd;
  logic               acc_sat;
  logic [SHIFT_W-1:0] out_shift;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_data;
  logic [7:0]         out_ovf;

  int checks   = 0;
  int failures = 0;

  mathb_simd_mac #(.DATA_W(DATA_W), .GUARD_W(8), .SHIFT_W(SHIFT_W)) dut (
    .EFPGA2MATHB_CLK(EFPGA2MATHB_CLK),
    .acc_ff_rstn(acc_ff_rstn),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .oper_data(oper_data),
    .coef_data(coef_data),
    .mode(mode),
    .tc(tc),
    .acc_clear(acc_clear),
    .acc_rnd(acc_rnd),
    .acc_sat(acc_sat),
    .out_shift(out_shift),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_ovf(out_ovf)
  );

  always #5 EFPGA2MATHB_CLK = ~EFPGA2MATHB_CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge EFPGA2MATHB_CLK);
    #1;
  endtask

  task automatic drive(input logic [31:0] op, input logic [31:0] cf, input logic [1:0] md,
                       input logic t, input logic clr, input logic rnd, input logic sat,
                       input logic [6:0] sh);
    in_valid  = 1'b1;
    oper_data = op;
    coef_data = cf;
    mode      = md;
    tc        = t;
    acc_clear = clr;
    acc_rnd   = rnd;
    acc_sat   = sat;
    out_shift = sh;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    acc_clear = 1'b0;
  endtask

  initial begin
    acc_ff_rstn = 1'b0;
    out_ready   = 1'b1;
    drive(32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0);
    idle();
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_ovf", {24'd0, out_ovf}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    acc_ff_rstn = 1'b1;
    tick();
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // x1 signed accumulate: 3*5 then + (-2)*4
    drive(32'd3, 32'd5, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 7'd0); tick();
    drive(32'hFFFFFFFE, 32'd4, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 7'd0); tick();
    idle(); tick();
    chk("x1_a_valid", {31'd0, out_valid}, 32'd1);
    chk("x1_a_data", out_data, 32'h0000000F);
    chk("x1_a_ovf", {24'd0, out_ovf}, 32'd0);
    tick();
    chk("x1_b_valid", {31'd0, out_valid}, 32'd1);
    chk("x1_b_data", out_data, 32'h00000007);
    tick();
    chk("x1_drain_valid", {31'd0, out_valid}, 32'd0);

    // x4 output saturation vs truncation
    drive(32'h7F7F7F7F, 32'h02020202, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 7'd0); tick();
    drive(32'h7F7F7F7F, 32'h02020202, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 7'd0); tick();
    idle(); tick();
    chk("x4_sat_data", out_data, 32'h7F7F7F7F);
    chk("x4_sat_ovf", {24'd0, out_ovf}, 32'h0000000F);
    tick();
    chk("x4_wrap_data", out_data, 32'hFEFEFEFE);
    chk("x4_wrap_ovf", {24'd0, out_ovf}, 32'h0000000F);
    tick();
    chk("x4_drain_valid", {31'd0, out_valid}, 32'd0);

    // x2 unsigned rounding with shift 4
    drive(32'h00180018, 32'h00010001, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 7'd4); tick();
    drive(32'h00180018, 32'h00010001, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 7'd4); tick();
    idle(); tick();
    chk("x2_rnd_data", out_data, 32'h00020002);
    chk("x2_rnd_ovf", {24'd0, out_ovf}, 32'd0);
    tick();
    chk("x2_trunc_data", out_data, 32'h00010001);
    tick();
    chk("x2_drain_valid", {31'd0, out_valid}, 32'd0);

    // Backpressure: four beats, out_ready low for 5 cycles from first result
    drive(32'd1, 32'd1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 7'd0); tick();
    drive(32'd2, 32'd1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 7'd0); tick();
    drive(32'd3, 32'd1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 7'd0); tick();
    drive(32'd4, 32'd1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 7'd0);
    out_ready = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_stall_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_stall_data", out_data, 32'd1);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_r1_data", out_data, 32'd1);
    tick();
    idle();
    chk("bp_r2_data", out_data, 32'd3);
    tick();
    chk("bp_r3_data", out_data, 32'd6);
    tick();
    chk("bp_r4_data", out_data, 32'd10);
    chk("bp_r4_valid", {31'd0, out_valid}, 32'd1);
    tick();
    chk("bp_drain_valid", {31'd0, out_valid}, 32'd0);

    // Implicit clear on mode change x1 -> x8
    drive(32'd10, 32'd10, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 7'd0); tick();
    drive(32'd10, 32'd10, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 7'd0); tick();
    drive(32'h22222222, 32'h33333333, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 7'd0); tick();
    idle();
    chk("ic_x1_a_data", out_data, 32'd100);
    tick();
    chk("ic_x1_b_data", out_data, 32'd200);
    tick();
    chk("ic_x8_data", out_data, 32'h66666666);
    chk("ic_x8_ovf", {24'd0, out_ovf}, 32'd0);
    tick();
    chk("ic_drain_valid", {31'd0, out_valid}, 32'd0);

    // Reset mid-stream with a result on the output and two beats in flight
    drive(32'd5, 32'd5, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 7'd0); tick();
    drive(32'd6, 32'd6, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 7'd0); tick();
    drive(32'd7, 32'd7, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 7'd0); tick();
    idle();
    chk("mr_pre_valid", {31'd0, out_valid}, 32'd1);
    chk("mr_pre_data", out_data, 32'd25);
    acc_ff_rstn = 1'b0;
    #1;
    chk("mr_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mr_out_data", out_data, 32'd0);
    chk("mr_out_ovf", {24'd0, out_ovf}, 32'd0);
    chk("mr_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    acc_ff_rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mr_no_flushed_result", {31'd0, out_valid}, 32'd0);
    end
    // Accumulator and stored mode were reset: no-clear x1 beat starts from zero
    drive(32'd5, 32'd5, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 7'd0); tick();
    idle(); tick(); tick();
    chk("mr_acc_zero_valid", {31'd0, out_valid}, 32'd1);
    chk("mr_acc_zero_data", out_data, 32'd25);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
